// File: rtl/cal_ctrl_pkg.sv
// Shared types and widths for the calibration launch controller.
// The optional busy watchdog is enabled with the CAL_TIMEOUT_EN macro.
package cal_ctrl_pkg;

    localparam int CNT_W   = 16;
    localparam int RETRY_W = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_SETTLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } cal_state_e;

endpackage

// File: rtl/cal_ctrl_cnt.sv
// Loadable down-counter that stops at zero; times the settle phase and,
// when CAL_TIMEOUT_EN is defined, the busy watchdog.
module cal_ctrl_cnt
    import cal_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cal_launch_ctrl.sv
// Sequences reset/init/start of a downstream transceiver calibration block,
// checks its per-channel result and retries. CAL_TIMEOUT_EN adds a busy watchdog.
module cal_launch_ctrl
    import cal_ctrl_pkg::*;
#(
    parameter int number_of_channels = 1,
    parameter int settle_cycles      = 16,
    parameter int timeout_cycles     = 1024,
    parameter int max_retries        = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          req,
    input  logic                          xcvr_ready,
    input  logic                          cal_busy,
    input  logic [number_of_channels-1:0] cal_error,
    output logic                          cal_reset,
    output logic                          cal_init,
    output logic                          cal_start,
    output logic                          done,
    output logic                          fail,
    output logic [number_of_channels-1:0] err_mask,
    output logic [RETRY_W-1:0]            retry_cnt,
    output logic                          timeout
);

    // Counter is loaded with N-1 on entry so a state lasts exactly N cycles.
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(settle_cycles - 1);
    localparam logic [CNT_W-1:0]   WAIT_LOAD   = CNT_W'(timeout_cycles - 1);
    localparam logic [RETRY_W-1:0] MAX_R       = RETRY_W'(max_retries);

    cal_state_e       state, state_nxt;
    logic [1:0]       rst_sync;
    logic             rst_n_int;
    logic             clr_stats, ld_err, inc_retry;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    // Assert asynchronously, release two edges later.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rst_sync <= '0;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

`ifdef CAL_TIMEOUT_EN
    logic wd_trip;
    logic timeout_q;
`endif

    always_comb begin
        state_nxt = state;
        clr_stats = 1'b0;
        ld_err    = 1'b0;
        inc_retry = 1'b0;
`ifdef CAL_TIMEOUT_EN
        wd_trip   = 1'b0;
`endif
        if (state != ST_IDLE && !xcvr_ready) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && xcvr_ready) begin
                        state_nxt = ST_INIT;
                        clr_stats = 1'b1;
                    end
                end
                ST_INIT:   state_nxt = ST_SETTLE;
                ST_SETTLE: if (cnt_zero) state_nxt = ST_START;
                ST_START:  state_nxt = ST_WAIT_BUSY;
                ST_WAIT_BUSY: begin
                    if (cal_busy)
                        state_nxt = ST_WAIT_DONE;
`ifdef CAL_TIMEOUT_EN
                    else if (cnt_zero) begin
                        state_nxt = ST_CHECK;
                        wd_trip   = 1'b1;
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!cal_busy) begin
                        state_nxt = ST_CHECK;
                        ld_err    = 1'b1;
                    end
`ifdef CAL_TIMEOUT_EN
                    else if (cnt_zero) begin
                        state_nxt = ST_CHECK;
                        wd_trip   = 1'b1;
                    end
`endif
                end
                ST_CHECK: begin
                    if (err_mask == '0 && !timeout) begin
                        state_nxt = ST_DONE;
                    end else if (retry_cnt < MAX_R) begin
                        state_nxt = ST_INIT;
                        inc_retry = 1'b1;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end
                ST_DONE, ST_FAIL: if (!req) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Every state entry reloads the counter; without the watchdog nothing
    // observes the value loaded for the wait states.
    assign cnt_load = (state_nxt != state);

    always_comb begin
        cnt_val = '0;
        case (state_nxt)
            ST_SETTLE:                 cnt_val = SETTLE_LOAD;
            ST_WAIT_BUSY, ST_WAIT_DONE: cnt_val = WAIT_LOAD;
            default:                   cnt_val = '0;
        endcase
    end

    cal_ctrl_cnt u_cnt (
        .clock    (clock),
        .reset_n  (rst_n_int),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            err_mask  <= '0;
            retry_cnt <= '0;
        end else begin
            if (clr_stats) begin
                err_mask  <= '0;
                retry_cnt <= '0;
            end
            if (ld_err)
                err_mask <= cal_error;
`ifdef CAL_TIMEOUT_EN
            if (wd_trip)
                err_mask <= '1;
`endif
            if (inc_retry)
                retry_cnt <= retry_cnt + 1'b1;
        end
    end

`ifdef CAL_TIMEOUT_EN
    // timeout describes only the most recent attempt.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int)
            timeout_q <= 1'b0;
        else if (clr_stats || ld_err)
            timeout_q <= 1'b0;
        else if (wd_trip)
            timeout_q <= 1'b1;
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign cal_reset = (state == ST_IDLE) || (state == ST_INIT);
    assign cal_init  = (state == ST_IDLE) || (state == ST_INIT) || (state == ST_SETTLE);
    assign cal_start = (state == ST_START);
    assign done      = (state == ST_DONE);
    assign fail      = (state == ST_FAIL);

endmodule
